// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the mem_arbiter block.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ACK} arb_state_t;

    localparam int MEM_AW  = 5;
    localparam int MEM_DW  = 8;
    localparam int MAX_REQ = 8;

    // First requesting index after 'last', wrapping modulo n (n <= MAX_REQ).
    // Returns 'last' when nothing is requesting.
    function automatic logic [2:0] rr_next(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int         n);
        logic [2:0] w;
        int         idx;
        w = last;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (req[idx[2:0]]) w = idx[2:0];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: winner is the first requester after 'last'.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [7:0] req8;
    logic [2:0] last3;
    logic [2:0] pick;

    // Widen to the helper's fixed width and select the winner.
    always_comb begin
        req8              = '0;
        req8[NREQ-1:0]    = req;
        last3             = '0;
        last3[IW-1:0]     = last;
        pick              = rr_next(req8, last3, NREQ);
        winner            = pick[IW-1:0];
        valid             = |req;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between
// NREQ requesters. Each grant runs IDLE -> ACCESS -> RESP -> ACK.
// Optional: MEM_ARBITER_PROTO_CHECK_EN adds a sticky proto_err output.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = MEM_AW,
    parameter int DW   = MEM_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic               mem_read,
    output logic               mem_write,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
`ifdef MEM_ARBITER_PROTO_CHECK_EN
   ,output logic               proto_err
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t          state, state_d;
    logic [IW-1:0]       ptr, ptr_d;
    logic [IW-1:0]       gnt, gnt_d;
    logic                lat_we, lat_we_d;
    logic [AW-1:0]       addr_d;
    logic [DW-1:0]       wdata_d;
    logic                read_d, write_d;
    logic [DW-1:0]       rdata_d;
    logic [NREQ-1:0]     ack_d;
    logic                busy_d;

    logic [IW-1:0]       pick_w;
    logic                pick_v;

    logic [AW-1:0]       addr_a  [NREQ];
    logic [DW-1:0]       wdata_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*AW +: AW];
        assign wdata_a[i] = req_wdata[i*DW +: DW];
    end

    mem_arb_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .last   (ptr),
        .winner (pick_w),
        .valid  (pick_v)
    );

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        gnt_d    = gnt;
        lat_we_d = lat_we;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        read_d   = 1'b0;
        write_d  = 1'b0;
        rdata_d  = rdata;
        ack_d    = '0;
        case (state)
            IDLE: begin
                if (pick_v) begin
                    gnt_d    = pick_w;
                    ptr_d    = pick_w;
                    lat_we_d = req_we[pick_w];
                    addr_d   = addr_a[pick_w];
                    wdata_d  = wdata_a[pick_w];
                    read_d   = !req_we[pick_w];
                    write_d  = req_we[pick_w];
                    state_d  = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                // Memory output now reflects the ACCESS edge.
                if (!lat_we) rdata_d = mem_rdata;
                ack_d[gnt] = 1'b1;
                state_d    = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ - 1);
            gnt       <= '0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rdata     <= '0;
            ack       <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            gnt       <= gnt_d;
            lat_we    <= lat_we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_read  <= read_d;
            mem_write <= write_d;
            rdata     <= rdata_d;
            ack       <= ack_d;
            busy      <= busy_d;
        end
    end

`ifdef MEM_ARBITER_PROTO_CHECK_EN
    logic [NREQ-1:0] r_req, r_ack, r_we;
    logic [AW-1:0]   r_addr [NREQ];
    logic            viol;

    // A violation is the granted req falling mid-access, or a pending
    // requester changing its fields before it has seen ack.
    always_comb begin
        viol = ((state == ACCESS) || (state == RESP)) && !req[gnt];
        for (int i = 0; i < NREQ; i++) begin
            if (r_req[i] && req[i] && !ack[i] && !r_ack[i] &&
                ((req_we[i] != r_we[i]) || (addr_a[i] != r_addr[i])))
                viol = 1'b1;
        end
    end

    // Previous-cycle request snapshot and the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req     <= '0;
            r_ack     <= '0;
            r_we      <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < NREQ; i++) r_addr[i] <= '0;
        end else begin
            r_req <= req;
            r_ack <= ack;
            r_we  <= req_we;
            for (int i = 0; i < NREQ; i++) r_addr[i] <= addr_a[i];
            if (viol) proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked against a grant-order / shadow-memory reference model.
module tb_mem_arbiter;

    localparam int NREQ  = 2;
    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic               mem_read, mem_write;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
`ifdef MEM_ARBITER_PROTO_CHECK_EN
    logic               proto_err;
`endif

    // Per-requester request fields driven by the tasks.
    logic          t_we    [NREQ];
    logic [AW-1:0] t_addr  [NREQ];
    logic [DW-1:0] t_wdata [NREQ];

    // Reference model state.
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_last;
    int            order [32];
    int            n_order;
    logic [DW-1:0] last_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARBITER_PROTO_CHECK_EN
       ,.proto_err (proto_err)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_we[i]              = t_we[i];
            req_addr[i*AW +: AW]   = t_addr[i];
            req_wdata[i*DW +: DW]  = t_wdata[i];
        end
    end

    // Synchronous single-port memory; filled with a known pattern once.
    logic [DW-1:0] mem [DEPTH];
    bit            init_done;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i * 29 + 7);
            init_done <= 1'b1;
        end else begin
            if (mem_write) mem[mem_addr] <= mem_wdata;
            if (mem_read)  mem_rdata     <= mem[mem_addr];
        end
    end

    function automatic int model_pick(input logic [NREQ-1:0] pend, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic rand_fields(input int i);
        t_we[i]    = 1'($urandom_range(0, 1));
        t_addr[i]  = AW'($urandom_range(0, DEPTH - 1));
        t_wdata[i] = DW'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_last = NREQ - 1;
    endtask

    // Hold 'mask' requesting until n_txn acks arrive; checks winner, latency,
    // ack width, strobe exclusivity and read data against the model.
    task automatic serve(input logic [NREQ-1:0] mask, input int n_txn, input bit keep);
        logic [NREQ-1:0] pend, oh;
        int done, cyc, next_ack, exp;
        bit prev_ack;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL serve_idle busy=%b required 0", busy);
        end
        pend = mask; req = pend;
        done = 0; cyc = 0; next_ack = 3; prev_ack = 0; n_order = 0;
        while (done < n_txn && cyc < 200) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (mem_read === 1'b1 && mem_write === 1'b1) begin
                errors++;
                $display("FAIL strobe_excl read=%b write=%b required not both", mem_read, mem_write);
            end
            if (prev_ack) begin
                checks++;
                if (ack !== '0) begin
                    errors++;
                    $display("FAIL ack_width ack=%b required 0", ack);
                end
                prev_ack = 0;
            end else if (ack != '0) begin
                exp = model_pick(pend, ref_last);
                if (exp < 0) exp = 0;
                oh = '0; oh[exp] = 1'b1;
                checks++;
                if (ack !== oh) begin
                    errors++;
                    $display("FAIL ack_winner ack=%b required %b", ack, oh);
                end
                checks++;
                if (cyc != next_ack) begin
                    errors++;
                    $display("FAIL ack_latency cycle=%0d required %0d", cyc, next_ack);
                end
                if (!t_we[exp]) begin
                    checks++;
                    if (rdata !== ref_mem[t_addr[exp]]) begin
                        errors++;
                        $display("FAIL rdata req%0d addr=%0d got=%h required %h",
                                 exp, t_addr[exp], rdata, ref_mem[t_addr[exp]]);
                    end
                    last_rdata = rdata;
                end else begin
                    ref_mem[t_addr[exp]] = t_wdata[exp];
                end
                if (n_order < 32) order[n_order] = exp;
                n_order++;
                ref_last = exp;
                done++;
                next_ack = cyc + 4;
                prev_ack = 1;
                if (keep) rand_fields(exp);
                else begin
                    pend[exp] = 1'b0;
                    req = pend;
                end
            end
        end
        checks++;
        if (done < n_txn) begin
            errors++;
            $display("FAIL serve_timeout acks=%0d required %0d", done, n_txn);
        end
        req = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (ack !== '0 || rdata !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out ack=%b rdata=%h busy=%b required 0", ack, rdata, busy);
        end
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mem rd=%b wr=%b addr=%h wdata=%h required 0",
                     mem_read, mem_write, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        ref_last = NREQ - 1;
    endtask

    task automatic test_write_read();
        t_we[0] = 1'b1; t_addr[0] = 5; t_wdata[0] = 8'hA5;
        serve(2'b01, 1, 0);
        t_we[0] = 1'b0;
        serve(2'b01, 1, 0);
        checks++;
        if (last_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL write_read rdata=%h required a5", last_rdata);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        t_we[0] = 1'b0; t_addr[0] = 3;
        t_we[1] = 1'b0; t_addr[1] = 9;
        serve(2'b11, 2, 0);
        checks++;
        if (order[0] != 0 || order[1] != 1) begin
            errors++;
            $display("FAIL simul_order got=%0d,%0d required 0,1", order[0], order[1]);
        end
    endtask

    task automatic test_contention();
        int bad;
        rand_fields(0); rand_fields(1);
        serve(2'b11, 8, 1);
        bad = 0;
        for (int k = 0; k < 8; k++) if (order[k] != (k % 2)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL contention_order wrong=%0d required 0 (0,1,0,1...)", bad);
        end
    endtask

    task automatic test_cross();
        t_we[1] = 1'b1; t_addr[1] = 31; t_wdata[1] = 8'h3C;
        serve(2'b10, 1, 0);
        t_we[0] = 1'b0; t_addr[0] = 31;
        serve(2'b01, 1, 0);
        checks++;
        if (last_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL cross_rd31 rdata=%h required 3c", last_rdata);
        end
        t_we[1] = 1'b1; t_addr[1] = 0; t_wdata[1] = 8'h00;
        serve(2'b10, 1, 0);
        t_we[0] = 1'b0; t_addr[0] = 0;
        serve(2'b01, 1, 0);
        checks++;
        if (last_rdata !== 8'h00) begin
            errors++;
            $display("FAIL cross_rd0 rdata=%h required 00", last_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        t_we[0] = 1'b0; t_addr[0] = 5;
        @(negedge clk);
        req = 2'b01;
        n = 0;
        while (mem_read !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_access mem_read=%b required 1", mem_read);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ack !== '0 || busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop ack=%b busy=%b rd=%b wr=%b required 0",
                     ack, busy, mem_read, mem_write);
        end
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_last = NREQ - 1;
        t_we[1] = 1'b0; t_addr[1] = 31;
        serve(2'b11, 2, 0);
        checks++;
        if (order[0] != 0) begin
            errors++;
            $display("FAIL rstmid_ptr first=%0d required 0", order[0]);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] m;
        for (int r = 0; r < 20; r++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) rand_fields(i);
            serve(m, $countones(m), 0);
        end
        for (int i = 0; i < NREQ; i++) rand_fields(i);
        serve('1, 6, 1);
    endtask

`ifdef MEM_ARBITER_PROTO_CHECK_EN
    task automatic test_proto();
        int n;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_clean proto_err=%b required 0", proto_err);
        end
        t_we[0] = 1'b0; t_addr[0] = 7;
        @(negedge clk);
        req = 2'b01;
        n = 0;
        while (mem_read !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);  // now in RESP
        req = '0;
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_set proto_err=%b required 1", proto_err);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky proto_err=%b required 1", proto_err);
        end
        do_reset();
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_rst proto_err=%b required 0", proto_err);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            t_we[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i * 29 + 7);
        ref_last   = NREQ - 1;
        last_rdata = '0;
        n_order    = 0;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_contention();
        test_cross();
        test_reset_mid();
        test_random();
`ifdef MEM_ARBITER_PROTO_CHECK_EN
        test_proto();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
